// File: rtl/pwm_ramp_sequencer.sv
// pwm_ramp_sequencer: SPI-written enable/duty registers; an IDLE/WAIT/STEP FSM ramps pwm_duty_cycle toward ramp_target, with ramp_busy and a ramp_done pulse
module pwm_ramp_sequencer #(
  parameter int PRESC_SHIFT = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_valid,
  input  logic [6:0] wr_addr,
  input  logic [7:0] wr_data,
  output logic [7:0] en_reg_out_7_0,
  output logic [7:0] en_reg_out_15_8,
  output logic [7:0] en_reg_pwm_7_0,
  output logic [7:0] en_reg_pwm_15_8,
  output logic [7:0] pwm_duty_cycle,
  output logic       ramp_busy,
  output logic       ramp_done
);
  localparam int CW = 8 + PRESC_SHIFT;
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_STEP} state_t;
  state_t state, state_n;
  logic [7:0] ramp_target, ramp_step, ramp_interval, duty_n, stepped, st;
  logic [CW-1:0] cnt, cnt_n, reload;
  logic [8:0] sum, diff;
  logic [8:0] sel;
  logic done_n, start, abort;
  always_comb begin
    for (int i = 0; i < 9; i++) sel[i] = wr_valid && wr_addr == 7'(i);
    start = sel[8] && wr_data[0];
    abort = sel[8] && wr_data[1];
    reload = ((CW'(ramp_interval) + CW'(1)) << PRESC_SHIFT) - CW'(1);
    st = ramp_step == 8'd0 ? 8'd1 : ramp_step;
    sum = {1'b0, pwm_duty_cycle} + {1'b0, st};
    diff = {1'b0, pwm_duty_cycle} - {1'b0, st};
    stepped = pwm_duty_cycle < ramp_target ? (sum > {1'b0, ramp_target} ? ramp_target : sum[7:0])
            : ((diff[8] || diff[7:0] < ramp_target) ? ramp_target : diff[7:0]);
    state_n = state;
    cnt_n = cnt;
    duty_n = pwm_duty_cycle;
    done_n = 1'b0;
    if (sel[4]) begin
      duty_n = wr_data;
      state_n = S_IDLE;
    end else if (abort) begin
      state_n = S_IDLE;
    end else if (start) begin
      if (state == S_IDLE && pwm_duty_cycle == ramp_target) done_n = 1'b1;
      else begin
        state_n = S_WAIT;
        cnt_n = reload;
      end
    end else begin
      case (state)
        S_WAIT: begin
          cnt_n = cnt == '0 ? '0 : cnt - CW'(1);
          state_n = cnt <= CW'(1) ? S_STEP : S_WAIT;
        end
        S_STEP: begin
          duty_n = stepped;
          done_n = stepped == ramp_target;
          state_n = stepped == ramp_target ? S_IDLE : S_WAIT;
          cnt_n = reload;
        end
        default: state_n = S_IDLE;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cnt <= '0;
      pwm_duty_cycle <= '0;
      ramp_done <= 1'b0;
      en_reg_out_7_0 <= '0;
      en_reg_out_15_8 <= '0;
      en_reg_pwm_7_0 <= '0;
      en_reg_pwm_15_8 <= '0;
      ramp_target <= '0;
      ramp_step <= '0;
      ramp_interval <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      pwm_duty_cycle <= duty_n;
      ramp_done <= done_n;
      en_reg_out_7_0 <= sel[0] ? wr_data : en_reg_out_7_0;
      en_reg_out_15_8 <= sel[1] ? wr_data : en_reg_out_15_8;
      en_reg_pwm_7_0 <= sel[2] ? wr_data : en_reg_pwm_7_0;
      en_reg_pwm_15_8 <= sel[3] ? wr_data : en_reg_pwm_15_8;
      ramp_target <= sel[5] ? wr_data : ramp_target;
      ramp_step <= sel[6] ? wr_data : ramp_step;
      ramp_interval <= sel[7] ? wr_data : ramp_interval;
    end
  end
  assign ramp_busy = state != S_IDLE;
endmodule

// File: tb/tb_pwm_ramp_sequencer.sv
// tb_pwm_ramp_sequencer: vector table, directed ramp sequences and random writes checked against a cycle-count model
module tb_pwm_ramp_sequencer;
  localparam int P = 2;
  logic clk = 0, rst = 1, wr_valid = 0;
  logic [6:0] wr_addr = 0;
  logic [7:0] wr_data = 0;
  logic [7:0] en0, en1, pw0, pw1, duty;
  logic busy, done;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  pwm_ramp_sequencer #(.PRESC_SHIFT(P)) dut (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
    .en_reg_out_7_0(en0), .en_reg_out_15_8(en1), .en_reg_pwm_7_0(pw0), .en_reg_pwm_15_8(pw1),
    .pwm_duty_cycle(duty), .ramp_busy(busy), .ramp_done(done)
  );
  typedef struct {
    logic r, v;
    logic [6:0] a;
    logic [7:0] d, e0, e1, p0, p1, du;
    logic bz, dn;
  } vec_t;
  vec_t tbl [11];
  logic [7:0] m_en [4];
  logic [7:0] m_duty = 0, m_tgt = 0, m_step = 0, m_int = 0;
  logic m_busy = 0, m_done = 0;
  int cyc = 0, due = 0, md, mt, ms;
  bit ctl;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask
  task automatic model_step();
    cyc = cyc + 1;
    m_done = 0;
    if (rst) begin
      for (int i = 0; i < 4; i++) m_en[i] = 0;
      m_duty = 0; m_tgt = 0; m_step = 0; m_int = 0; m_busy = 0;
    end else begin
      ms = m_step == 0 ? 1 : int'(m_step);
      ctl = wr_valid && (wr_addr == 7'h04 || (wr_addr == 7'h08 && wr_data[1:0] != 2'b00));
      if (m_busy && !ctl && cyc == due) begin
        md = int'(m_duty);
        mt = int'(m_tgt);
        md = md < mt ? ((md + ms > mt) ? mt : md + ms) : ((md - ms < mt) ? mt : md - ms);
        m_duty = 8'(md);
        if (md == mt) begin
          m_busy = 0;
          m_done = 1;
        end else due = cyc + ((int'(m_int) + 1) << P);
      end
      if (wr_valid) begin
        if (wr_addr < 7'h04) m_en[wr_addr[1:0]] = wr_data;
        else if (wr_addr == 7'h04) begin
          m_duty = wr_data;
          m_busy = 0;
        end
        else if (wr_addr == 7'h05) m_tgt = wr_data;
        else if (wr_addr == 7'h06) m_step = wr_data;
        else if (wr_addr == 7'h07) m_int = wr_data;
        else if (wr_addr == 7'h08) begin
          if (wr_data[1]) m_busy = 0;
          else if (wr_data[0]) begin
            if (!m_busy && m_duty == m_tgt) m_done = 1;
            else begin
              m_busy = 1;
              due = cyc + ((int'(m_int) + 1) << P);
            end
          end
        end
      end
    end
  endtask
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    chk("model_en0", en0, m_en[0]);
    chk("model_en1", en1, m_en[1]);
    chk("model_pw0", pw0, m_en[2]);
    chk("model_pw1", pw1, m_en[3]);
    chk("model_duty", duty, m_duty);
    chk("model_busy", busy, m_busy);
    chk("model_done", done, m_done);
  endtask
  task automatic wr(input logic [6:0] a, input logic [7:0] d);
    wr_valid = 1;
    wr_addr = a;
    wr_data = d;
    tick();
    wr_valid = 0;
  endtask
  initial begin
    tbl[0]  = '{1, 1, 7'h00, 8'h55, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0};
    tbl[1]  = '{0, 1, 7'h00, 8'hA5, 8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0};
    tbl[2]  = '{0, 1, 7'h03, 8'h3C, 8'hA5, 8'h00, 8'h00, 8'h3C, 8'h00, 0, 0};
    tbl[3]  = '{0, 1, 7'h09, 8'hFF, 8'hA5, 8'h00, 8'h00, 8'h3C, 8'h00, 0, 0};
    tbl[4]  = '{0, 1, 7'h7F, 8'hFF, 8'hA5, 8'h00, 8'h00, 8'h3C, 8'h00, 0, 0};
    tbl[5]  = '{0, 1, 7'h01, 8'h11, 8'hA5, 8'h11, 8'h00, 8'h3C, 8'h00, 0, 0};
    tbl[6]  = '{0, 1, 7'h02, 8'h22, 8'hA5, 8'h11, 8'h22, 8'h3C, 8'h00, 0, 0};
    tbl[7]  = '{0, 1, 7'h04, 8'h40, 8'hA5, 8'h11, 8'h22, 8'h3C, 8'h40, 0, 0};
    tbl[8]  = '{0, 1, 7'h05, 8'h40, 8'hA5, 8'h11, 8'h22, 8'h3C, 8'h40, 0, 0};
    tbl[9]  = '{0, 1, 7'h08, 8'h01, 8'hA5, 8'h11, 8'h22, 8'h3C, 8'h40, 0, 1};
    tbl[10] = '{0, 0, 7'h00, 8'h00, 8'hA5, 8'h11, 8'h22, 8'h3C, 8'h40, 0, 0};
    for (int i = 0; i < 11; i++) begin
      rst = tbl[i].r;
      wr_valid = tbl[i].v;
      wr_addr = tbl[i].a;
      wr_data = tbl[i].d;
      tick();
      chk("tbl_en0", en0, tbl[i].e0);
      chk("tbl_en1", en1, tbl[i].e1);
      chk("tbl_pw0", pw0, tbl[i].p0);
      chk("tbl_pw1", pw1, tbl[i].p1);
      chk("tbl_duty", duty, tbl[i].du);
      chk("tbl_busy", busy, tbl[i].bz);
      chk("tbl_done", done, tbl[i].dn);
    end
    rst = 0;
    wr_valid = 0;
    wr(7'h04, 8'h10); wr(7'h05, 8'h30); wr(7'h06, 8'h08); wr(7'h07, 8'h00); wr(7'h08, 8'h01);
    chk("up_busy0", busy, 1);
    for (int k = 0; k < 4; k++)
      for (int j = 0; j < 4; j++) begin
        tick();
        chk("up_duty", duty, j == 3 ? 8'h18 + 8'(8 * k) : 8'h10 + 8'(8 * k));
        chk("up_done", done, k == 3 && j == 3);
        chk("up_busy", busy, !(k == 3 && j == 3));
      end
    tick();
    chk("up_done_off", done, 0);
    wr(7'h04, 8'hFE); wr(7'h05, 8'hFF); wr(7'h06, 8'h10); wr(7'h08, 8'h01);
    repeat (3) tick();
    chk("sat_hi_hold", duty, 8'hFE);
    tick();
    chk("sat_hi_duty", duty, 8'hFF);
    chk("sat_hi_done", done, 1);
    wr(7'h04, 8'h05); wr(7'h05, 8'h00); wr(7'h08, 8'h01);
    repeat (4) tick();
    chk("sat_lo_duty", duty, 8'h00);
    chk("sat_lo_done", done, 1);
    wr(7'h04, 8'h10); wr(7'h05, 8'hF0); wr(7'h06, 8'h01); wr(7'h08, 8'h01);
    repeat (3) tick();
    wr(7'h04, 8'h80);
    chk("spi_win_duty", duty, 8'h80);
    chk("spi_win_busy", busy, 0);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("spi_win_done", done, 0);
      chk("spi_win_hold", duty, 8'h80);
    end
    wr(7'h05, 8'h00); wr(7'h08, 8'h01);
    repeat (5) tick();
    chk("pre_abort_duty", duty, 8'h7F);
    wr(7'h08, 8'h03);
    chk("abort_busy", busy, 0);
    chk("abort_duty", duty, 8'h7F);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("abort_done", done, 0);
      chk("abort_hold", duty, 8'h7F);
    end
    wr(7'h07, 8'h02); wr(7'h05, 8'h10); wr(7'h08, 8'h01);
    repeat (2) tick();
    chk("rst_pre_busy", busy, 1);
    rst = 1;
    tick();
    chk("rst_outs", {en0, en1, pw0, pw1}, 0);
    chk("rst_duty", duty, 0);
    chk("rst_busy", busy, 0);
    rst = 0;
    wr(7'h08, 8'h01);
    chk("rst_start_done", done, 1);
    chk("rst_start_busy", busy, 0);
    tick();
    chk("rst_done_off", done, 0);
    for (int n = 0; n < 4000; n++) begin
      int a;
      rst = $urandom_range(0, 299) == 0;
      wr_valid = $urandom_range(0, 5) == 0;
      a = $urandom_range(0, 11);
      wr_addr = a > 9 ? 7'($urandom_range(9, 127)) : 7'(a);
      wr_data = (wr_addr == 7'h07 || wr_addr == 7'h08) ? 8'($urandom_range(0, 3))
              : wr_addr == 7'h06 ? 8'($urandom_range(0, 40)) : 8'($urandom_range(0, 255));
      tick();
    end
    rst = 0;
    wr_valid = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
